// File: rtl/switch_debouncer.sv
// Per-bit switch conditioning: 2-flop synchronizer, stability counter,
// committed debounced level and one-cycle rise/fall pulses.
module switch_debouncer #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_switches_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_any_edge
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             any_q;
  logic             any_d;

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

  // State register; synchronizer runs regardless of enable
  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      any_q    <= 1'b0;
    end else begin
      s1       <= in_switches_raw;
      s2       <= s1;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      any_q    <= any_d;
    end
  end

  // Next state: idle / counting / commit per bit
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = '0;
    fall_d   = '0;
    if (enable) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (1'b1)
          (s2[i] == stable_q[i]): begin
            cnt_d[i] = '0;
          end
          (s2[i] != stable_q[i]) && (cnt_q[i] == CNT_MAX): begin
            stable_d[i] = s2[i];
            cnt_d[i]    = '0;
            rise_d[i]   = s2[i];
            fall_d[i]   = ~s2[i];
          end
          default: begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        endcase
      end
    end
  end

  always_comb begin
    any_d = (|rise_d) | (|fall_d);
  end

  // Outputs come straight from registers
  always_comb begin
    sw_stable   = stable_q;
    sw_rise     = rise_q;
    sw_fall     = fall_q;
    sw_any_edge = any_q;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after an edge; that edge is "edge 0".
module tb_switch_debouncer;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] in_switches_raw;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_any_edge;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .in_switches_raw(in_switches_raw),
    .sw_stable(sw_stable),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .sw_any_edge(sw_any_edge)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] ex(
    input logic [3:0] s,
    input logic [3:0] r,
    input logic [3:0] f,
    input logic       a
  );
    return {s, r, f, a};
  endfunction

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {sw_stable, sw_rise, sw_fall, sw_any_edge};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    in_switches_raw = 4'b0000;
    tick(2);
    chk("reset_state", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));
    reset = 1'b0;
    tick(2);
    chk("idle", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));

    // Clean press on bit 0: commit at edge 6
    in_switches_raw = 4'b0001;
    tick(5);
    chk("press_pre", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));
    tick(1);
    chk("press_commit", ex(4'b0001, 4'b0001, 4'b0000, 1'b1));
    tick(1);
    chk("press_post", ex(4'b0001, 4'b0000, 4'b0000, 1'b0));

    // 3-cycle glitch on bit 1: rejected
    in_switches_raw = 4'b0011;
    tick(3);
    in_switches_raw = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      chk("glitch3", ex(4'b0001, 4'b0000, 4'b0000, 1'b0));
      tick(1);
    end

    // 4-cycle pulse on bit 1: rise at edge 6, fall at edge 10
    in_switches_raw = 4'b0011;
    tick(4);
    in_switches_raw = 4'b0001;
    tick(1);
    chk("pulse4_pre", ex(4'b0001, 4'b0000, 4'b0000, 1'b0));
    tick(1);
    chk("pulse4_rise", ex(4'b0011, 4'b0010, 4'b0000, 1'b1));
    tick(1);
    chk("pulse4_hold", ex(4'b0011, 4'b0000, 4'b0000, 1'b0));
    tick(3);
    chk("pulse4_fall", ex(4'b0001, 4'b0000, 4'b0010, 1'b1));
    tick(1);
    chk("pulse4_post", ex(4'b0001, 4'b0000, 4'b0000, 1'b0));

    // Bounce on bit 2 every 2 cycles, final toggle at edge 12
    for (int k = 0; k < 12; k++) begin
      in_switches_raw = {1'b0, ((k / 2) % 2 == 0), 2'b01};
      tick(1);
      chk("bounce", ex(4'b0001, 4'b0000, 4'b0000, 1'b0));
    end
    in_switches_raw = 4'b0101;
    tick(5);
    chk("bounce_pre", ex(4'b0001, 4'b0000, 4'b0000, 1'b0));
    tick(1);
    chk("bounce_rise", ex(4'b0101, 4'b0100, 4'b0000, 1'b1));
    tick(1);
    chk("bounce_post", ex(4'b0101, 4'b0000, 4'b0000, 1'b0));

    // Simultaneous release of bits 0 and 2
    in_switches_raw = 4'b0000;
    tick(6);
    chk("dual_fall", ex(4'b0000, 4'b0000, 4'b0101, 1'b1));
    tick(1);
    chk("dual_fall_post", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));

    // Simultaneous press of bits 3 and 1
    in_switches_raw = 4'b1010;
    tick(5);
    chk("simul_pre", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));
    tick(1);
    chk("simul_rise", ex(4'b1010, 4'b1010, 4'b0000, 1'b1));
    tick(1);
    chk("simul_post", ex(4'b1010, 4'b0000, 4'b0000, 1'b0));
    in_switches_raw = 4'b0000;
    tick(6);
    chk("simul_fall", ex(4'b0000, 4'b0000, 4'b1010, 1'b1));
    tick(1);
    chk("simul_fall_post", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));

    // Reset while bit 3 has cnt=2
    in_switches_raw = 4'b1000;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("rst_mid", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));
    reset = 1'b0;
    tick(5);
    chk("rst_mid_pre", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));
    tick(1);
    chk("rst_mid_rise", ex(4'b1000, 4'b1000, 4'b0000, 1'b1));
    tick(1);
    chk("rst_mid_post", ex(4'b1000, 4'b0000, 4'b0000, 1'b0));

    // Reset with a committed level: clears, no pulses, recommits
    reset = 1'b1;
    tick(1);
    chk("rst_stable", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));
    reset = 1'b0;
    tick(1);
    chk("rst_release", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));
    tick(4);
    chk("rst_rel_pre", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));
    tick(1);
    chk("rst_rel_rise", ex(4'b1000, 4'b1000, 4'b0000, 1'b1));
    in_switches_raw = 4'b0000;
    tick(6);
    chk("rst_rel_fall", ex(4'b0000, 4'b0000, 4'b1000, 1'b1));
    tick(1);

    // Enable freeze with sw_stable=0001
    in_switches_raw = 4'b0001;
    tick(6);
    chk("frz_setup", ex(4'b0001, 4'b0001, 4'b0000, 1'b1));
    tick(1);
    enable = 1'b0;
    in_switches_raw = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("frz_hold", ex(4'b0001, 4'b0000, 4'b0000, 1'b0));
    end
    enable = 1'b1;
    tick(3);
    chk("frz_resume_pre", ex(4'b0001, 4'b0000, 4'b0000, 1'b0));
    tick(1);
    chk("frz_resume_fall", ex(4'b0000, 4'b0000, 4'b0001, 1'b1));
    tick(1);
    chk("frz_resume_post", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));

    // Pause at cnt=2, resume from held count: commit 2 edges later
    in_switches_raw = 4'b0001;
    tick(4);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("pause_hold", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));
    end
    enable = 1'b1;
    tick(1);
    chk("pause_resume_pre", ex(4'b0000, 4'b0000, 4'b0000, 1'b0));
    tick(1);
    chk("pause_resume_rise", ex(4'b0001, 4'b0001, 4'b0000, 1'b1));
    tick(1);
    chk("pause_resume_post", ex(4'b0001, 4'b0000, 4'b0000, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
